ray_marcher: RTL and testbench



---
 rtl/ray_marcher.sv | 238 +++++++++++++++++++++++
 tb/tb_ray_marcher.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ray_marcher.sv
// rtl/ray_marcher.sv - per-ray sphere-tracing march controller driving the sdf evaluator
`timescale 1ns/1ps
module ray_marcher #(
  parameter int          SDF_LATENCY = 12,
  parameter int          MUL_LATENCY = 2,
  parameter int          ADD_LATENCY = 2,
  parameter int          MAX_STEPS   = 64,
  parameter logic [26:0] EPSILON     = 27'h1e3d70a,
  parameter logic [26:0] MAX_DIST    = 27'h2480000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic [26:0] i_origin_x,
  input  logic [26:0] i_origin_y,
  input  logic [26:0] i_origin_z,
  input  logic [26:0] i_dir_x,
  input  logic [26:0] i_dir_y,
  input  logic [26:0] i_dir_z,
  output logic        o_ready,
  output logic [26:0] o_point_x,
  output logic [26:0] o_point_y,
  output logic [26:0] o_point_z,
  input  logic [26:0] i_distance,
  output logic        o_done,
  output logic        o_hit,
  output logic [26:0] o_t,
  output logic [7:0]  o_steps
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_MUL   = 3'd4;
  localparam logic [2:0] S_ADD   = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  localparam logic [7:0] SDF_LAST  = 8'(SDF_LATENCY - 1);
  localparam logic [7:0] MUL_LAST  = 8'(MUL_LATENCY - 1);
  localparam logic [7:0] ADD_LAST  = 8'(ADD_LATENCY - 1);
  localparam logic [7:0] STEPS_MAX = 8'(MAX_STEPS);

  // Truncating 27-bit float multiply; denormal inputs and underflow flush to zero.
  function automatic logic [26:0] fp_mul(input logic [26:0] a, input logic [26:0] b);
    logic [37:0]       prod;
    logic signed [9:0] e;
    logic [17:0]       m;
    begin
      prod = {19'd0, 1'b1, a[17:0]} * {19'd0, 1'b1, b[17:0]};
      e = $signed({2'b00, a[25:18]}) + $signed({2'b00, b[25:18]}) - 10'sd127;
      if (prod[37]) begin
        m = prod[36:19];
        e = e + 10'sd1;
      end else begin
        m = prod[35:18];
      end
      if (a[25:18] == 8'd0 || b[25:18] == 8'd0 || e <= 10'sd0) fp_mul = 27'd0;
      else if (e >= 10'sd255) fp_mul = {a[26] ^ b[26], 8'hfe, 18'h3ffff};
      else fp_mul = {a[26] ^ b[26], e[7:0], m};
    end
  endfunction

  // Truncating 27-bit float add; the larger magnitude operand sets the result sign.
  function automatic logic [26:0] fp_add(input logic [26:0] a, input logic [26:0] b);
    logic [26:0]       x, y;
    logic [7:0]        sh;
    logic [20:0]       mx, my, s;
    logic signed [9:0] e;
    begin
      if (a[25:0] >= b[25:0]) begin
        x = a;
        y = b;
      end else begin
        x = b;
        y = a;
      end
      sh = x[25:18] - y[25:18];
      mx = (x[25:18] == 8'd0) ? 21'd0 : {2'b01, x[17:0], 1'b0};
      my = (y[25:18] == 8'd0) ? 21'd0 : ({2'b01, y[17:0], 1'b0} >> sh);
      e  = $signed({2'b00, x[25:18]});
      s  = (x[26] == y[26]) ? mx + my : mx - my;
      if (s[20]) begin
        s = s >> 1;
        e = e + 10'sd1;
      end
      for (int i = 0; i < 20; i++) begin
        if (s != 21'd0 && !s[19]) begin
          s = s << 1;
          e = e - 10'sd1;
        end
      end
      if (s == 21'd0 || e <= 10'sd0) fp_add = 27'd0;
      else if (e >= 10'sd255) fp_add = {x[26], 8'hfe, 18'h3ffff};
      else fp_add = {x[26], e[7:0], s[18:1]};
    end
  endfunction

  logic [2:0]  r_state;
  logic [7:0]  r_cnt;
  logic [7:0]  r_steps;
  logic [26:0] r_dir_x, r_dir_y, r_dir_z;
  logic [26:0] r_p_x, r_p_y, r_p_z;
  logic [26:0] r_t, r_d;
  logic [26:0] r_prod_x, r_prod_y, r_prod_z;
  logic [26:0] r_point_x, r_point_y, r_point_z;
  logic        r_hit;
  logic [26:0] r_t_out;
  logic [7:0]  r_steps_out;

  logic [26:0] w_prod_x, w_prod_y, w_prod_z;
  logic [26:0] w_sum_x, w_sum_y, w_sum_z, w_t_next;
  logic        w_hit, w_far;

  always_comb begin
    w_prod_x = fp_mul(r_d, r_dir_x);
    w_prod_y = fp_mul(r_d, r_dir_y);
    w_prod_z = fp_mul(r_d, r_dir_z);
    w_sum_x  = fp_add(r_p_x, r_prod_x);
    w_sum_y  = fp_add(r_p_y, r_prod_y);
    w_sum_z  = fp_add(r_p_z, r_prod_z);
    w_t_next = fp_add(r_t, r_d);
    // Positive floats order the same as their unsigned bit patterns.
    w_hit    = r_d[26] | (r_d[25:0] < EPSILON[25:0]);
    w_far    = w_t_next[25:0] >= MAX_DIST[25:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 8'd0;
      r_steps     <= 8'd0;
      r_dir_x     <= 27'd0;
      r_dir_y     <= 27'd0;
      r_dir_z     <= 27'd0;
      r_p_x       <= 27'd0;
      r_p_y       <= 27'd0;
      r_p_z       <= 27'd0;
      r_t         <= 27'd0;
      r_d         <= 27'd0;
      r_prod_x    <= 27'd0;
      r_prod_y    <= 27'd0;
      r_prod_z    <= 27'd0;
      r_point_x   <= 27'd0;
      r_point_y   <= 27'd0;
      r_point_z   <= 27'd0;
      r_hit       <= 1'b0;
      r_t_out     <= 27'd0;
      r_steps_out <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_dir_x <= i_dir_x;
            r_dir_y <= i_dir_y;
            r_dir_z <= i_dir_z;
            r_p_x   <= i_origin_x;
            r_p_y   <= i_origin_y;
            r_p_z   <= i_origin_z;
            r_t     <= 27'd0;
            r_steps <= 8'd0;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_point_x <= r_p_x;
          r_point_y <= r_p_y;
          r_point_z <= r_p_z;
          r_cnt     <= 8'd0;
          r_state   <= S_WAIT;
        end
        S_WAIT: begin
          if (r_cnt == SDF_LAST) begin
            r_d     <= i_distance;
            r_steps <= (r_steps == STEPS_MAX) ? r_steps : r_steps + 8'd1;
            r_cnt   <= 8'd0;
            r_state <= S_CHECK;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_CHECK: begin
          if (w_hit || r_steps == STEPS_MAX) begin
            r_hit       <= w_hit;
            r_t_out     <= r_t;
            r_steps_out <= r_steps;
            r_state     <= S_DONE;
          end else begin
            r_cnt   <= 8'd0;
            r_state <= S_MUL;
          end
        end
        S_MUL: begin
          r_prod_x <= w_prod_x;
          r_prod_y <= w_prod_y;
          r_prod_z <= w_prod_z;
          if (r_cnt == MUL_LAST) begin
            r_cnt   <= 8'd0;
            r_state <= S_ADD;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_ADD: begin
          if (r_cnt == ADD_LAST) begin
            r_p_x <= w_sum_x;
            r_p_y <= w_sum_y;
            r_p_z <= w_sum_z;
            r_t   <= w_t_next;
            r_cnt <= 8'd0;
            if (w_far) begin
              r_hit       <= 1'b0;
              r_t_out     <= w_t_next;
              r_steps_out <= r_steps;
              r_state     <= S_DONE;
            end else begin
              r_state <= S_ISSUE;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_ready   = (r_state == S_IDLE);
  assign o_done    = (r_state == S_DONE);
  assign o_hit     = r_hit;
  assign o_t       = r_t_out;
  assign o_steps   = r_steps_out;
  assign o_point_x = r_point_x;
  assign o_point_y = r_point_y;
  assign o_point_z = r_point_z;

endmodule

// File: tb/tb_ray_marcher.sv
// tb/tb_ray_marcher.sv - directed bench for ray_marcher with behavioural sdf models
`timescale 1ns/1ps
module tb_ray_marcher;

  localparam int SDF_LAT = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start_a, start_b, start_c;
  logic [26:0] org_x, org_y, org_z, dir_x, dir_y, dir_z;

  logic        rdy_a, rdy_b, rdy_c, done_a, done_b, done_c, hit_a, hit_b, hit_c;
  logic [26:0] px_a, py_a, pz_a, px_b, py_b, pz_b, px_c, py_c, pz_c;
  logic [26:0] dist_a, dist_b, dist_c, t_a, t_b, t_c;
  logic [7:0]  st_a, st_b, st_c;

  int checks = 0;
  int failures = 0;
  int mode_a = 0;
  int cur = 0;

  // Instance a: default parameters. b: max distance 8.0. c: step budget of 4.
  ray_marcher dut_a (
    .clk(clk), .reset(reset), .i_start(start_a),
    .i_origin_x(org_x), .i_origin_y(org_y), .i_origin_z(org_z),
    .i_dir_x(dir_x), .i_dir_y(dir_y), .i_dir_z(dir_z),
    .o_ready(rdy_a), .o_point_x(px_a), .o_point_y(py_a), .o_point_z(pz_a),
    .i_distance(dist_a), .o_done(done_a), .o_hit(hit_a), .o_t(t_a), .o_steps(st_a));

  ray_marcher #(.MAX_DIST(27'h2080000)) dut_b (
    .clk(clk), .reset(reset), .i_start(start_b),
    .i_origin_x(org_x), .i_origin_y(org_y), .i_origin_z(org_z),
    .i_dir_x(dir_x), .i_dir_y(dir_y), .i_dir_z(dir_z),
    .o_ready(rdy_b), .o_point_x(px_b), .o_point_y(py_b), .o_point_z(pz_b),
    .i_distance(dist_b), .o_done(done_b), .o_hit(hit_b), .o_t(t_b), .o_steps(st_b));

  ray_marcher #(.MAX_STEPS(4)) dut_c (
    .clk(clk), .reset(reset), .i_start(start_c),
    .i_origin_x(org_x), .i_origin_y(org_y), .i_origin_z(org_z),
    .i_dir_x(dir_x), .i_dir_y(dir_y), .i_dir_z(dir_z),
    .o_ready(rdy_c), .o_point_x(px_c), .o_point_y(py_c), .o_point_z(pz_c),
    .i_distance(dist_c), .o_done(done_c), .o_hit(hit_c), .o_t(t_c), .o_steps(st_c));

  function automatic real to_real(input logic [26:0] v);
    real r;
    int  e;
    if (v[25:18] == 8'd0) return 0.0;
    r = 1.0 + real'(v[17:0]) / 262144.0;
    e = int'(v[25:18]) - 127;
    for (int i = 0; i < e; i++) r = r * 2.0;
    for (int i = 0; i < -e; i++) r = r / 2.0;
    return v[26] ? -r : r;
  endfunction

  function automatic logic [26:0] from_real(input real r);
    real         m;
    int          e;
    logic [17:0] f;
    if (r == 0.0) return 27'd0;
    m = (r < 0.0) ? -r : r;
    e = 127;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0) begin m = m * 2.0; e--; end
    f = 18'($rtoi((m - 1.0) * 262144.0));
    return {r < 0.0, 8'(e), f};
  endfunction

  // Mode 0: unit sphere at the origin, 1: constant 1.0, 2: constant -1.0.
  function automatic logic [26:0] sdf_eval(input logic [80:0] p, input int mode);
    real x, y, z;
    if (mode == 1) return 27'h1fc0000;
    if (mode == 2) return 27'h5fc0000;
    x = to_real(p[80:54]);
    y = to_real(p[53:27]);
    z = to_real(p[26:0]);
    return from_real($sqrt(x * x + y * y + z * z) - 1.0);
  endfunction

  // Point history so the distance seen at the capture edge belongs to the point issued SDF_LAT edges earlier.
  logic [80:0] hist_a [SDF_LAT-1];
  logic [80:0] hist_b [SDF_LAT-1];
  logic [80:0] hist_c [SDF_LAT-1];
  always @(posedge clk) begin
    hist_a[0] <= {px_a, py_a, pz_a};
    hist_b[0] <= {px_b, py_b, pz_b};
    hist_c[0] <= {px_c, py_c, pz_c};
    for (int i = 1; i < SDF_LAT - 1; i++) begin
      hist_a[i] <= hist_a[i-1];
      hist_b[i] <= hist_b[i-1];
      hist_c[i] <= hist_c[i-1];
    end
  end
  always_comb dist_a = sdf_eval(hist_a[SDF_LAT-2], mode_a);
  always_comb dist_b = sdf_eval(hist_b[SDF_LAT-2], 1);
  always_comb dist_c = sdf_eval(hist_c[SDF_LAT-2], 1);

  logic        m_ready, m_done, m_hit;
  logic [26:0] m_t, m_pz;
  logic [7:0]  m_steps;
  always_comb begin
    m_ready = (cur == 0) ? rdy_a  : (cur == 1) ? rdy_b  : rdy_c;
    m_done  = (cur == 0) ? done_a : (cur == 1) ? done_b : done_c;
    m_hit   = (cur == 0) ? hit_a  : (cur == 1) ? hit_b  : hit_c;
    m_t     = (cur == 0) ? t_a    : (cur == 1) ? t_b    : t_c;
    m_pz    = (cur == 0) ? pz_a   : (cur == 1) ? pz_b   : pz_c;
    m_steps = (cur == 0) ? st_a   : (cur == 1) ? st_b   : st_c;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // lat counts clock edges strictly between the start-acceptance edge and the edge raising o_done.
  task automatic march(input string tag, input int which, input int pulse_at,
                       output int lat, output int pz_changes, output int ready_hi);
    logic [26:0] last_pz;
    bit          seen;
    cur = which;
    for (int i = 0; i < 20 && !m_ready; i++) @(negedge clk);
    chk({tag, "_ready_before"}, 32'(m_ready), 32'd1);
    last_pz = m_pz;
    pz_changes = 0;
    ready_hi = 0;
    lat = 0;
    seen = 0;
    @(negedge clk);
    if (which == 0) start_a = 1'b1; else if (which == 1) start_b = 1'b1; else start_c = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (pulse_at == i) begin
        start_a = 1'b1;
        org_z = 27'h6088000;
      end
      @(posedge clk);
      #1;
      start_a = 1'b0;
      if (m_pz != last_pz) begin
        pz_changes++;
        last_pz = m_pz;
      end
      if (m_done) begin
        seen = 1;
        break;
      end
      if (m_ready) ready_hi++;
      lat++;
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  int lat, pzc, rhi, ndone;

  initial begin
    reset = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    org_x = 27'd0; org_y = 27'd0; org_z = 27'h6050000;
    dir_x = 27'd0; dir_y = 27'd0; dir_z = 27'h1fc0000;
    repeat (3) @(negedge clk);
    cur = 0;
    #1;
    chk("rst_ready", 32'(m_ready), 32'd1);
    chk("rst_done", 32'(m_done), 32'd0);
    chk("rst_hit", 32'(m_hit), 32'd0);
    chk("rst_t", 32'(m_t), 32'd0);
    chk("rst_steps", 32'(m_steps), 32'd0);
    chk("rst_pz", 32'(m_pz), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    mode_a = 0;
    march("sphere", 0, -1, lat, pzc, rhi);
    chk("sphere_hit", 32'(m_hit), 32'd1);
    chk("sphere_steps", 32'(m_steps), 32'd2);
    chk("sphere_t", 32'(m_t), 32'h2040000);
    chk("sphere_pz", 32'(m_pz), 32'h5fc0000);
    chk("sphere_lat", 32'(lat), 32'(2 * 18 - 5));
    @(posedge clk); #1;
    chk("sphere_done_pulse", 32'(m_done), 32'd0);
    chk("sphere_ready_after", 32'(m_ready), 32'd1);

    mode_a = 2;
    march("negd", 0, -1, lat, pzc, rhi);
    chk("negd_hit", 32'(m_hit), 32'd1);
    chk("negd_steps", 32'(m_steps), 32'd1);
    chk("negd_t", 32'(m_t), 32'd0);
    chk("negd_lat", 32'(lat), 32'(1 + SDF_LAT));
    chk("negd_pz", 32'(m_pz), 32'h6050000);

    mode_a = 0;
    march("busy", 0, 5, lat, pzc, rhi);
    chk("busy_hit", 32'(m_hit), 32'd1);
    chk("busy_steps", 32'(m_steps), 32'd2);
    chk("busy_t", 32'(m_t), 32'h2040000);
    chk("busy_pz", 32'(m_pz), 32'h5fc0000);
    chk("busy_ready_low", 32'(rhi), 32'd0);

    org_z = 27'd0;
    march("maxdist", 1, -1, lat, pzc, rhi);
    chk("maxdist_hit", 32'(m_hit), 32'd0);
    chk("maxdist_steps", 32'(m_steps), 32'd8);
    chk("maxdist_t", 32'(m_t), 32'h2080000);
    chk("maxdist_lat", 32'(lat), 32'(8 * 18 - 1));

    org_z = 27'h6050000;
    march("budget", 2, -1, lat, pzc, rhi);
    chk("budget_hit", 32'(m_hit), 32'd0);
    chk("budget_steps", 32'(m_steps), 32'd4);
    chk("budget_t", 32'(m_t), 32'h2020000);
    chk("budget_issues", 32'(pzc), 32'd4);
    chk("budget_pz", 32'(m_pz), 32'h6000000);

    cur = 0;
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (16) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_ready", 32'(m_ready), 32'd1);
    chk("midrst_done", 32'(m_done), 32'd0);
    chk("midrst_hit", 32'(m_hit), 32'd0);
    chk("midrst_t", 32'(m_t), 32'd0);
    chk("midrst_steps", 32'(m_steps), 32'd0);
    chk("midrst_pz", 32'(m_pz), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (m_done) ndone++;
    end
    chk("midrst_no_done", 32'(ndone), 32'd0);
    march("rerun", 0, -1, lat, pzc, rhi);
    chk("rerun_hit", 32'(m_hit), 32'd1);
    chk("rerun_steps", 32'(m_steps), 32'd2);
    chk("rerun_t", 32'(m_t), 32'h2040000);
    chk("rerun_pz", 32'(m_pz), 32'h5fc0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
